// File: rtl/ph_stream_tx.sv
// ph_stream_tx: AXI-stream master that serialises one pulse-height event.
// Packet: PRE_WORDS latency beats of PRE_PATTERN, PH_WORDS payload beats
// (two 12-bit samples fetched from a 16-bit BRAM per beat), then one
// elapsed-time beat carrying tlast.
module ph_stream_tx #(
  parameter int unsigned PRE_WORDS   = 20,
  parameter int unsigned PH_WORDS    = 128,
  parameter logic [31:0] PRE_PATTERN = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [28:0] time_in,
  output logic        busy,
  output logic        done,
  output logic [15:0] drop_cnt,
  output logic        src_rd_en,
  output logic [7:0]  src_raddr,
  input  logic [15:0] src_rdata,
  output logic [31:0] m_axis_tdata,
  output logic        m_axis_tvalid,
  output logic        m_axis_tlast,
  input  logic        m_axis_tready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_FETCH_LO,
    S_FETCH_HI,
    S_CAPTURE,
    S_SEND_PH,
    S_SEND_TIME
  } state_t;

  localparam logic [5:0] PRE_LAST = 6'(PRE_WORDS - 1);
  localparam logic [6:0] PH_LAST  = 7'(PH_WORDS - 1);

  state_t      state_q, state_d;
  logic [5:0]  pre_cnt_q, pre_cnt_d;
  logic [6:0]  k_q, k_d;
  logic [11:0] lo_q, lo_d;
  logic [28:0] time_q, time_d;
  logic [31:0] tdata_q, tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        tlast_q, tlast_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;
  logic [15:0] drop_q, drop_d;
  logic        xfer;

  assign xfer          = tvalid_q & m_axis_tready;
  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tlast  = tlast_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign drop_cnt      = drop_q;

  // Next-state, registered stream outputs and BRAM read port decode.
  // Stream outputs are registered so tvalid never depends on tready; the
  // read port is decoded from state so data lands one cycle later.
  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    k_d       = k_q;
    lo_d      = lo_q;
    time_d    = time_q;
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    drop_d    = drop_q;
    src_rd_en = 1'b0;
    src_raddr = '0;

    // Starts during a packet or on the done cycle are counted, not queued.
    if (start && (busy_q || done_q) && (drop_q != '1)) begin
      drop_d = drop_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (start && !done_q) begin
          time_d    = time_in;
          pre_cnt_d = '0;
          k_d       = '0;
          busy_d    = 1'b1;
          tvalid_d  = 1'b1;
          tlast_d   = 1'b0;
          tdata_d   = PRE_PATTERN;
          state_d   = S_PRE;
        end
      end

      S_PRE: begin
        if (xfer) begin
          if (pre_cnt_q == PRE_LAST) begin
            tvalid_d = 1'b0;
            k_d      = '0;
            state_d  = S_FETCH_LO;
          end else begin
            pre_cnt_d = pre_cnt_q + 6'd1;
          end
        end
      end

      S_FETCH_LO: begin
        src_rd_en = 1'b1;
        src_raddr = {k_q, 1'b0};
        state_d   = S_FETCH_HI;
      end

      S_FETCH_HI: begin
        src_rd_en = 1'b1;
        src_raddr = {k_q, 1'b1};
        lo_d      = src_rdata[11:0];
        state_d   = S_CAPTURE;
      end

      S_CAPTURE: begin
        tdata_d  = {4'h0, src_rdata[11:0], 4'h0, lo_q};
        tvalid_d = 1'b1;
        state_d  = S_SEND_PH;
      end

      S_SEND_PH: begin
        if (xfer) begin
          k_d = k_q + 7'd1;
          if (k_q == PH_LAST) begin
            // Time word follows the last payload beat with no gap.
            tdata_d  = {3'b000, time_q};
            tlast_d  = 1'b1;
            tvalid_d = 1'b1;
            state_d  = S_SEND_TIME;
          end else begin
            tvalid_d = 1'b0;
            state_d  = S_FETCH_LO;
          end
        end
      end

      S_SEND_TIME: begin
        if (xfer) begin
          tvalid_d = 1'b0;
          tlast_d  = 1'b0;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pre_cnt_q <= '0;
      k_q       <= '0;
      lo_q      <= '0;
      time_q    <= '0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      drop_q    <= '0;
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      k_q       <= k_d;
      lo_q      <= lo_d;
      time_q    <= time_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      drop_q    <= drop_d;
    end
  end

endmodule

// File: tb/tb_ph_stream_tx.sv
// Bench for ph_stream_tx: BRAM model, scoreboard of expected beats,
// table of packet vectors plus hand-written corner-case sequences.
module tb_ph_stream_tx;

  localparam int unsigned PRE    = 20;
  localparam int unsigned PH     = 128;
  localparam int unsigned NBEATS = PRE + PH + 1;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [28:0] time_in;
  logic        busy;
  logic        done;
  logic [15:0] drop_cnt;
  logic        src_rd_en;
  logic [7:0]  src_raddr;
  logic [15:0] src_rdata;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tlast;
  logic        m_axis_tready;

  always #5 clk = ~clk;

  ph_stream_tx #(
    .PRE_WORDS  (PRE),
    .PH_WORDS   (PH),
    .PRE_PATTERN(32'h0000_0000)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .time_in      (time_in),
    .busy         (busy),
    .done         (done),
    .drop_cnt     (drop_cnt),
    .src_rd_en    (src_rd_en),
    .src_raddr    (src_raddr),
    .src_rdata    (src_rdata),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tready(m_axis_tready)
  );

  // One-cycle-latency BRAM read port.
  logic [15:0] mem [256];
  always @(posedge clk) begin
    if (src_rd_en) src_rdata <= mem[src_raddr];
  end

  typedef struct {
    logic [31:0] data;
    logic        last;
  } beat_t;

  typedef struct {
    logic [28:0]  t;
    int unsigned  pat;
    int unsigned  rdy;
    logic [31:0]  first_ph;
    logic [31:0]  last_ph;
    logic [31:0]  time_word;
  } vec_t;

  beat_t       sb[$];
  vec_t        vecs [4];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  int unsigned rdy_mode;
  int unsigned beat_cnt = 0;
  int unsigned pkt_base = 0;
  logic        hold_v = 1'b0;
  logic [31:0] hold_d;
  logic        hold_l;
  logic        exp_done = 1'b0;
  logic [31:0] cap_first, cap_last, cap_time;
  logic [15:0] exp_drop;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Samples DUT outputs mid-cycle; a beat seen with tvalid&tready here
  // transfers at the following rising edge.
  task automatic monitor();
    beat_t e;
    int unsigned idx;
    if (!rst_n) begin
      sb.delete();
      hold_v   = 1'b0;
      exp_done = 1'b0;
      return;
    end
    if (exp_done) begin
      chk("done_pulse", {31'b0, done}, 32'd1);
      exp_done = 1'b0;
    end else if (done) begin
      chk("spurious_done", {31'b0, done}, 32'd0);
    end
    if (src_rd_en) chk("rd_en_while_pending", {31'b0, m_axis_tvalid}, 32'd0);
    if (hold_v) begin
      chk("hold_tvalid", {31'b0, m_axis_tvalid}, 32'd1);
      chk("hold_tdata", m_axis_tdata, hold_d);
      chk("hold_tlast", {31'b0, m_axis_tlast}, {31'b0, hold_l});
    end
    if (m_axis_tvalid && m_axis_tready) begin
      if (sb.size() == 0) begin
        chk("unexpected_beat", 32'(sb.size()), 32'd1);
      end else begin
        e = sb.pop_front();
        chk("beat_data", m_axis_tdata, e.data);
        chk("beat_last", {31'b0, m_axis_tlast}, {31'b0, e.last});
      end
      idx = beat_cnt - pkt_base;
      if (idx == PRE) cap_first = m_axis_tdata;
      if (idx == PRE + PH - 1) cap_last = m_axis_tdata;
      if (m_axis_tlast) begin
        cap_time = m_axis_tdata;
        exp_done = 1'b1;
      end
      beat_cnt++;
      hold_v = 1'b0;
    end else if (m_axis_tvalid) begin
      hold_v = 1'b1;
      hold_d = m_axis_tdata;
      hold_l = m_axis_tlast;
    end else begin
      hold_v = 1'b0;
    end
  endtask

  // One clock: monitor at the falling edge, inputs change 1 time unit
  // after the rising edge.
  task automatic tick();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    if (rdy_mode == 2) m_axis_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic set_rdy(input int unsigned m);
    rdy_mode = m;
    if (m == 0) m_axis_tready = 1'b0;
    else if (m == 1) m_axis_tready = 1'b1;
    else m_axis_tready = 1'($urandom_range(0, 1));
  endtask

  task automatic load_mem(input int unsigned pat);
    logic [7:0] b;
    for (int unsigned a = 0; a < 256; a++) begin
      b = 8'(a);
      if (pat == 2) mem[a] = {b, ~b};
      else mem[a] = {8'h00, b};
    end
    if (pat == 1) begin
      mem[0] = 16'hFABC;
      mem[1] = 16'h8123;
    end
  endtask

  // Expected packet built from the BRAM contents and the time value.
  task automatic push_packet(input logic [28:0] t);
    beat_t  e;
    logic [15:0] lo, hi;
    for (int unsigned i = 0; i < PRE; i++) begin
      e.data = 32'h0; e.last = 1'b0; sb.push_back(e);
    end
    for (int unsigned k = 0; k < PH; k++) begin
      lo = mem[2 * k];
      hi = mem[2 * k + 1];
      e.data = {4'h0, hi[11:0], 4'h0, lo[11:0]};
      e.last = 1'b0;
      sb.push_back(e);
    end
    e.data = {3'b000, t}; e.last = 1'b1; sb.push_back(e);
    pkt_base = beat_cnt;
  endtask

  task automatic start_packet(input logic [28:0] t);
    push_packet(t);
    time_in = t;
    start   = 1'b1;
    tick();
    start   = 1'b0;
    chk("busy_after_start", {31'b0, busy}, 32'd1);
    chk("first_tvalid_latency", {31'b0, m_axis_tvalid}, 32'd1);
  endtask

  task automatic wait_done(input string name);
    int unsigned n = 0;
    while (done !== 1'b1 && n < 8000) begin
      tick();
      n++;
    end
    if (done !== 1'b1) chk({name, "_timeout"}, {31'b0, done}, 32'd1);
  endtask

  task automatic end_packet(input string name, input logic [31:0] time_word);
    chk({name, "_beats"}, beat_cnt - pkt_base, NBEATS);
    chk({name, "_busy_clear"}, {31'b0, busy}, 32'd0);
    chk({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
    chk({name, "_time_word"}, cap_time, time_word);
  endtask

  initial begin
    vecs[0] = '{t: 29'h0ABCDEF, pat: 0, rdy: 1, first_ph: 32'h0001_0000,
                last_ph: 32'h00FF_00FE, time_word: 32'h00AB_CDEF};
    vecs[1] = '{t: 29'h0ABCDEF, pat: 0, rdy: 2, first_ph: 32'h0001_0000,
                last_ph: 32'h00FF_00FE, time_word: 32'h00AB_CDEF};
    vecs[2] = '{t: 29'h1FFFFFFF, pat: 1, rdy: 1, first_ph: 32'h0123_0ABC,
                last_ph: 32'h00FF_00FE, time_word: 32'h1FFF_FFFF};
    vecs[3] = '{t: 29'h0000001, pat: 2, rdy: 2, first_ph: 32'h01FE_00FF,
                last_ph: 32'h0F00_0E01, time_word: 32'h0000_0001};

    rst_n   = 1'b0;
    start   = 1'b0;
    time_in = '0;
    set_rdy(1);
    load_mem(0);
    tick();
    tick();
    chk("rst_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
    chk("rst_tlast", {31'b0, m_axis_tlast}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_rd_en", {31'b0, src_rd_en}, 32'd0);
    chk("rst_tdata", m_axis_tdata, 32'd0);
    chk("rst_raddr", {24'b0, src_raddr}, 32'd0);
    chk("rst_drop_cnt", {16'b0, drop_cnt}, 32'd0);
    rst_n = 1'b1;
    tick();

    for (int unsigned i = 0; i < 4; i++) begin
      load_mem(vecs[i].pat);
      set_rdy(vecs[i].rdy);
      start_packet(vecs[i].t);
      wait_done("vec");
      end_packet("vec", vecs[i].time_word);
      chk("vec_first_ph", cap_first, vecs[i].first_ph);
      chk("vec_last_ph", cap_last, vecs[i].last_ph);
      tick();
    end

    // Starts mid-packet are dropped and leave the packet intact.
    exp_drop = 16'd0;
    load_mem(0);
    set_rdy(1);
    start_packet(29'h0123456);
    repeat (40) tick();
    for (int unsigned i = 0; i < 3; i++) begin
      time_in = 29'h1555555;
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      exp_drop = exp_drop + 16'd1;
    end
    wait_done("drop");
    end_packet("drop", 32'h0012_3456);
    chk("drop_cnt_3", {16'b0, drop_cnt}, {16'b0, exp_drop});

    // Start on the done cycle is dropped; start on the next cycle is taken.
    push_packet(29'h0000ABC);
    time_in = 29'h0000ABC;
    start = 1'b1;
    tick();
    exp_drop = exp_drop + 16'd1;
    chk("b2b_gap_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
    chk("b2b_done_cycle_drop", {16'b0, drop_cnt}, {16'b0, exp_drop});
    tick();
    start = 1'b0;
    chk("b2b_first_tvalid", {31'b0, m_axis_tvalid}, 32'd1);
    chk("b2b_busy", {31'b0, busy}, 32'd1);
    wait_done("b2b");
    end_packet("b2b", 32'h0000_0ABC);
    tick();

    // Reset while payload beat 50 is pending abandons the packet.
    start_packet(29'h0ABCDEF);
    begin
      int unsigned n = 0;
      while (!((beat_cnt - pkt_base == PRE + 50) && m_axis_tvalid) && n < 2000) begin
        tick();
        n++;
      end
      chk("rst_mid_reached", {31'b0, m_axis_tvalid}, 32'd1);
    end
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst_mid_tvalid", {31'b0, m_axis_tvalid}, 32'd0);
    chk("rst_mid_tlast", {31'b0, m_axis_tlast}, 32'd0);
    chk("rst_mid_done", {31'b0, done}, 32'd0);
    chk("rst_mid_busy", {31'b0, busy}, 32'd0);
    chk("rst_mid_drop", {16'b0, drop_cnt}, 32'd0);
    repeat (5) tick();
    set_rdy(2);
    start_packet(29'h0ABCDEF);
    wait_done("post_rst");
    end_packet("post_rst", 32'h00AB_CDEF);
    chk("post_rst_first_ph", cap_first, 32'h0001_0000);
    chk("post_rst_last_ph", cap_last, 32'h00FF_00FE);
    tick();

    // Drop counter saturation while a beat is stalled on tready.
    set_rdy(0);
    push_packet(29'h0000777);
    time_in = 29'h0000777;
    start = 1'b1;
    tick();
    chk("sat_busy", {31'b0, busy}, 32'd1);
    repeat (65535) tick();
    chk("drop_cnt_ffff", {16'b0, drop_cnt}, 32'h0000_FFFF);
    tick();
    chk("drop_cnt_saturate", {16'b0, drop_cnt}, 32'h0000_FFFF);
    start = 1'b0;
    set_rdy(1);
    wait_done("sat");
    end_packet("sat", 32'h0000_0777);
    repeat (3) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
